bitserial_subtractor: RTL and testbench

//  Sequential inverse of the full-adder datapath: computes A - B one bit per clock, LSB first.

---
 rtl/bitserial_subtractor_if.sv | 41 ++++
 rtl/bitserial_subtractor.sv | 125 ++++++++++++
 tb/tb_bitserial_subtractor.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/bitserial_subtractor_if.sv
// Handshake bundle for the bit-serial subtractor.
// The operand side (start_*, a, b) and the result side (done_*, diff, borrow_out, overflow)
// each use a valid/ready pair. The slave modport is the subtractor's view; the master modport
// is the view of the block that supplies operands and consumes results.
interface bitserial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start_valid;
   logic             start_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             done_valid;
   logic             done_ready;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
   logic             overflow;

   modport slave (
      input  start_valid,
      input  a,
      input  b,
      input  done_ready,
      output start_ready,
      output done_valid,
      output diff,
      output borrow_out,
      output overflow
   );

   modport master (
      output start_valid,
      output a,
      output b,
      output done_ready,
      input  start_ready,
      input  done_valid,
      input  diff,
      input  borrow_out,
      input  overflow
   );
endinterface

// File: rtl/bitserial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per clock, LSB first, using a single
// full-subtractor cell and a registered borrow. Operands are captured on the start handshake,
// the result is held on the done handshake until the consumer takes it.
// A start at edge k gives done_valid after edge k+WIDTH; the result is taken at the following
// edge, so with done_ready held high a new operand pair is accepted every WIDTH+2 cycles.
module bitserial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   bitserial_subtractor_if.slave bus
);

   // Bit counter only needs to reach WIDTH-1.
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_sh_q;
   logic [WIDTH-1:0] b_sh_q;
   logic             a_msb_q;
   logic             b_msb_q;
   logic             borrow_q;
   logic [CW-1:0]    count_q;
   logic [WIDTH-1:0] diff_q;
   logic             borrow_out_q;
   logic             overflow_q;
   logic             start_ready_q;
   logic             done_valid_q;

   // Full-subtractor cell operating on the current LSBs of the operand shift registers.
   logic a_bit;
   logic b_bit;
   logic d_bit;
   logic bout;

   // Single full-subtractor cell: difference bit and borrow-out for the current bit position.
   always_comb begin
      a_bit = a_sh_q[0];
      b_bit = b_sh_q[0];
      d_bit = a_bit ^ b_bit ^ borrow_q;
      bout  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_q);
   end

   // Control FSM and datapath registers; every handshake output comes straight from a flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         a_sh_q        <= '0;
         b_sh_q        <= '0;
         a_msb_q       <= 1'b0;
         b_msb_q       <= 1'b0;
         borrow_q      <= 1'b0;
         count_q       <= '0;
         diff_q        <= '0;
         borrow_out_q  <= 1'b0;
         overflow_q    <= 1'b0;
         start_ready_q <= 1'b1;
         done_valid_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               // start_ready is high throughout IDLE, so start_valid alone means a transfer.
               if (bus.start_valid) begin
                  a_sh_q        <= bus.a;
                  b_sh_q        <= bus.b;
                  // MSBs are kept aside because the shift registers are consumed by the end.
                  a_msb_q       <= bus.a[WIDTH-1];
                  b_msb_q       <= bus.b[WIDTH-1];
                  borrow_q      <= 1'b0;
                  count_q       <= '0;
                  start_ready_q <= 1'b0;
                  state_q       <= SHIFT;
               end
            end

            SHIFT: begin
               // New difference bit enters at the MSB so bit 0 lands in diff[0] after WIDTH shifts.
               diff_q   <= {d_bit, diff_q[WIDTH-1:1]};
               a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
               b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
               borrow_q <= bout;
               if (count_q == LAST_BIT) begin
                  // d_bit here is the final diff MSB, which is not in diff_q until after this edge.
                  borrow_out_q <= bout;
                  overflow_q   <= (a_msb_q != b_msb_q) & (d_bit != a_msb_q);
                  count_q      <= '0;
                  done_valid_q <= 1'b1;
                  state_q      <= DONE;
               end else begin
                  count_q <= count_q + 1'b1;
               end
            end

            DONE: begin
               // Result registers are untouched here; only the consumer's acceptance leaves DONE.
               if (bus.done_ready) begin
                  done_valid_q  <= 1'b0;
                  start_ready_q <= 1'b1;
                  state_q       <= IDLE;
               end
            end

            default: begin
               done_valid_q  <= 1'b0;
               start_ready_q <= 1'b1;
               state_q       <= IDLE;
            end
         endcase
      end
   end

   assign bus.start_ready = start_ready_q;
   assign bus.done_valid  = done_valid_q;
   assign bus.diff        = diff_q;
   assign bus.borrow_out  = borrow_out_q;
   assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_bitserial_subtractor.sv
// Directed bench for the bit-serial subtractor (WIDTH=8): fixed vectors, backpressure,
// mid-operation reset and a back-to-back sweep against an a-b golden model.
module tb_bitserial_subtractor;

   localparam int W = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   bitserial_subtractor_if #(.WIDTH(W)) bus ();

   bitserial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) at negedges until start_ready is high.
   task automatic wait_start_ready(input string tag);
      int n;
      n = 0;
      while (bus.start_ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_start_ready"}, {31'd0, bus.start_ready}, 32'd1);
   endtask

   // Wait (bounded) at negedges until done_valid; returns the number of edges waited.
   task automatic wait_done(input string tag, output int n);
      n = 0;
      while (bus.done_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done_valid"}, {31'd0, bus.done_valid}, 32'd1);
   endtask

   // One operation with done_ready high; checks latency, result and return to IDLE.
   task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] ed, input logic eb, input logic eo);
      int lat;
      wait_start_ready(tag);
      bus.a = av;
      bus.b = bv;
      bus.start_valid = 1'b1;
      bus.done_ready = 1'b1;
      @(negedge clk);
      bus.start_valid = 1'b0;
      bus.a = ~av;
      bus.b = ~bv;
      wait_done(tag, lat);
      check({tag, "_latency"}, lat, W);
      check({tag, "_diff"}, {24'd0, bus.diff}, {24'd0, ed});
      check({tag, "_borrow"}, {31'd0, bus.borrow_out}, {31'd0, eb});
      check({tag, "_ovf"}, {31'd0, bus.overflow}, {31'd0, eo});
      @(negedge clk);
      check({tag, "_idle_ready"}, {31'd0, bus.start_ready}, 32'd1);
      check({tag, "_idle_dv"}, {31'd0, bus.done_valid}, 32'd0);
      $display("op %s: a=%02h b=%02h diff=%02h borrow=%0b ovf=%0b", tag, av, bv, ed, eb, eo);
   endtask

   initial begin
      logic [7:0] ra, rb, ed;
      logic       eb, eo;
      logic [8:0] full;
      int         lat, stamp, prev_stamp;

      bus.start_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.done_ready = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_start_ready", {31'd0, bus.start_ready}, 32'd1);
      check("rst_done_valid", {31'd0, bus.done_valid}, 32'd0);
      check("rst_diff", {24'd0, bus.diff}, 32'd0);
      check("rst_borrow", {31'd0, bus.borrow_out}, 32'd0);
      check("rst_ovf", {31'd0, bus.overflow}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Directed vectors
      run_op("t1_100_37", 8'd100, 8'd37, 8'd63, 1'b0, 1'b0);
      run_op("t2_5_9", 8'd5, 8'd9, 8'hFC, 1'b1, 1'b0);
      run_op("t3_80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
      run_op("t3_7F_FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
      run_op("t3_00_80", 8'h00, 8'h80, 8'h80, 1'b1, 1'b1);
      run_op("t3_FF_FF", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);

      // Backpressure: 200-50=150, no borrow, no overflow
      wait_start_ready("t4");
      bus.a = 8'd200;
      bus.b = 8'd50;
      bus.start_valid = 1'b1;
      bus.done_ready = 1'b0;
      @(negedge clk);
      bus.start_valid = 1'b0;
      wait_done("t4", lat);
      check("t4_latency", lat, W);
      bus.a = 8'd3;
      bus.b = 8'd1;
      bus.start_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t4_hold_dv", {31'd0, bus.done_valid}, 32'd1);
         check("t4_hold_diff", {24'd0, bus.diff}, 32'h96);
         check("t4_hold_sr", {31'd0, bus.start_ready}, 32'd0);
         $display("t4 stall %0d: done_valid=%0b diff=%02h", i, bus.done_valid, bus.diff);
      end
      check("t4_borrow", {31'd0, bus.borrow_out}, 32'd0);
      check("t4_ovf", {31'd0, bus.overflow}, 32'd0);
      bus.start_valid = 1'b0;
      bus.done_ready = 1'b1;
      @(negedge clk);
      check("t4_release_sr", {31'd0, bus.start_ready}, 32'd1);
      check("t4_release_dv", {31'd0, bus.done_valid}, 32'd0);

      // Reset mid-SHIFT at count==3
      wait_start_ready("t5");
      bus.a = 8'h55;
      bus.b = 8'h22;
      bus.start_valid = 1'b1;
      @(negedge clk);
      bus.start_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      check("t5_abort_sr", {31'd0, bus.start_ready}, 32'd1);
      check("t5_abort_dv", {31'd0, bus.done_valid}, 32'd0);
      check("t5_abort_diff", {24'd0, bus.diff}, 32'd0);
      $display("t5 reset mid-shift: start_ready=%0b done_valid=%0b diff=%02h",
               bus.start_ready, bus.done_valid, bus.diff);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      run_op("t5_0_0", 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);

      // Back-to-back sweep against a-b golden model
      bus.done_ready = 1'b1;
      bus.start_valid = 1'b1;
      prev_stamp = 0;
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         full = {1'b0, ra} - {1'b0, rb};
         ed = full[7:0];
         eb = full[8];
         eo = (ra[7] != rb[7]) && (ed[7] != ra[7]);
         wait_start_ready("t6");
         bus.a = ra;
         bus.b = rb;
         stamp = cyc;
         if (i > 0) check("t6_spacing", stamp - prev_stamp, W + 2);
         prev_stamp = stamp;
         @(negedge clk);
         wait_done("t6", lat);
         check("t6_diff", {24'd0, bus.diff}, {24'd0, ed});
         check("t6_borrow", {31'd0, bus.borrow_out}, {31'd0, eb});
         check("t6_ovf", {31'd0, bus.overflow}, {31'd0, eo});
         $display("t6 %0d: a=%02h b=%02h diff=%02h borrow=%0b ovf=%0b", i, ra, rb,
                  bus.diff, bus.borrow_out, bus.overflow);
         @(negedge clk);
      end
      bus.start_valid = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
